neuron_mac_sequencer: RTL and testbench

//  Fabric-side engine behind the HPS "control" conduit. On start it fetches N = kernel_size^2

---
 rtl/neuron_mac_sequencer.sv | 176 +++++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// Fetches K*K image/weight word pairs over two Avalon-MM read masters and
// accumulates the signed 16x16 dot product, reporting result/done to software.
module neuron_mac_sequencer #(
  parameter logic [31:0] WEI_OFFSET = 32'h0001_0000,
  parameter logic [31:0] STRIDE     = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] base_addr,
  input  logic [7:0]  kernel_size,
  input  logic        start,
  input  logic        clear,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] addr_img,
  output logic [31:0] addr_wei,
  output logic        img_read,
  output logic        img_write,
  output logic [31:0] img_address,
  output logic [31:0] img_writedata,
  input  logic [31:0] img_readdata,
  input  logic        img_waitrequest,
  output logic        weight_read,
  output logic        weight_write,
  output logic [31:0] weight_address,
  output logic [31:0] weight_writedata,
  input  logic [31:0] weight_readdata,
  input  logic        weight_waitrequest
);

  typedef enum logic [2:0] {IDLE, FETCH, MAC, DONE, ABORT} state_t;

  state_t             state;
  logic        [15:0] n_elems;
  logic        [15:0] count;
  logic        [31:0] acc;
  logic        [15:0] img_data;
  logic        [15:0] wei_data;
  logic               img_got;
  logic               wei_got;
  logic               img_acc;
  logic               wei_acc;
  logic        [15:0] k_sq;
  logic signed [31:0] img_s;
  logic signed [31:0] wei_s;
  logic        [31:0] product;
  logic        [31:0] acc_next;
  logic               unused_hi;

  assign img_write        = 1'b0;
  assign weight_write     = 1'b0;
  assign img_writedata    = '0;
  assign weight_writedata = '0;
  assign img_address      = addr_img;
  assign weight_address   = addr_wei;

  assign img_acc   = img_read && !img_waitrequest;
  assign wei_acc   = weight_read && !weight_waitrequest;
  assign k_sq      = {8'd0, kernel_size} * {8'd0, kernel_size};
  assign img_s     = {{16{img_data[15]}}, img_data};
  assign wei_s     = {{16{wei_data[15]}}, wei_data};
  assign product   = img_s * wei_s;
  assign acc_next  = acc + product;
  assign unused_hi = ^{img_readdata[31:16], weight_readdata[31:16]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      result      <= '0;
      acc         <= '0;
      count       <= '0;
      n_elems     <= '0;
      addr_img    <= '0;
      addr_wei    <= '0;
      img_read    <= 1'b0;
      weight_read <= 1'b0;
      img_data    <= '0;
      wei_data    <= '0;
      img_got     <= 1'b0;
      wei_got     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (clear) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
          end else if (start) begin
            n_elems  <= k_sq;
            addr_img <= base_addr;
            addr_wei <= base_addr + WEI_OFFSET;
            acc      <= '0;
            count    <= '0;
            img_got  <= 1'b0;
            wei_got  <= 1'b0;
            if (k_sq == 16'd0) begin
              state  <= DONE;
              result <= '0;
              done   <= 1'b1;
            end else begin
              state       <= FETCH;
              done        <= 1'b0;
              img_read    <= 1'b1;
              weight_read <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (clear) begin
            // A read accepted in this very cycle is finished; one still stalled must persist.
            state       <= ABORT;
            img_read    <= img_read && img_waitrequest;
            weight_read <= weight_read && weight_waitrequest;
            img_got     <= 1'b0;
            wei_got     <= 1'b0;
          end else begin
            if (img_acc) begin
              img_data <= img_readdata[15:0];
              img_got  <= 1'b1;
              img_read <= 1'b0;
            end
            if (wei_acc) begin
              wei_data    <= weight_readdata[15:0];
              wei_got     <= 1'b1;
              weight_read <= 1'b0;
            end
            if ((img_got || img_acc) && (wei_got || wei_acc))
              state <= MAC;
          end
        end

        MAC: begin
          if (clear) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
          end else begin
            acc      <= acc_next;
            count    <= count + 16'd1;
            addr_img <= addr_img + STRIDE;
            addr_wei <= addr_wei + STRIDE;
            img_got  <= 1'b0;
            wei_got  <= 1'b0;
            if (count + 16'd1 == n_elems) begin
              state  <= DONE;
              result <= acc_next;
              done   <= 1'b1;
            end else begin
              state       <= FETCH;
              img_read    <= 1'b1;
              weight_read <= 1'b1;
            end
          end
        end

        ABORT: begin
          if (img_acc) img_read <= 1'b0;
          if (wei_acc) weight_read <= 1'b0;
          if ((!img_read || img_acc) && (!weight_read || wei_acc)) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench: table of runs against modelled Avalon slaves with
// programmable stalls, plus hand-written abort/restart/clear sequences.
module tb_neuron_mac_sequencer;

  localparam logic [31:0] WEI_OFF = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset, start, clear;
  logic [31:0] base_addr;
  logic [7:0]  kernel_size;
  logic        done;
  logic [31:0] result, addr_img, addr_wei;
  logic        img_read, img_write, weight_read, weight_write;
  logic [31:0] img_address, img_writedata, img_readdata;
  logic [31:0] weight_address, weight_writedata, weight_readdata;
  logic        img_waitrequest, weight_waitrequest;

  neuron_mac_sequencer #(.WEI_OFFSET(WEI_OFF), .STRIDE(32'd4)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .kernel_size(kernel_size),
    .start(start), .clear(clear), .done(done), .result(result),
    .addr_img(addr_img), .addr_wei(addr_wei),
    .img_read(img_read), .img_write(img_write), .img_address(img_address),
    .img_writedata(img_writedata), .img_readdata(img_readdata),
    .img_waitrequest(img_waitrequest),
    .weight_read(weight_read), .weight_write(weight_write),
    .weight_address(weight_address), .weight_writedata(weight_writedata),
    .weight_readdata(weight_readdata), .weight_waitrequest(weight_waitrequest)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Slave memories and stall model
  logic [31:0] img_mem [16];
  logic [31:0] wei_mem [16];
  logic [31:0] cur_base = '0;
  int unsigned iwait = 0, wwait = 0, icnt = 0, wcnt = 0;
  logic [31:0] img_idx, wei_idx;

  assign img_waitrequest    = img_read && (icnt < iwait);
  assign weight_waitrequest = weight_read && (wcnt < wwait);
  assign img_idx = (img_address - cur_base) >> 2;
  assign wei_idx = (weight_address - cur_base - WEI_OFF) >> 2;
  assign img_readdata    = (img_idx < 32'd9) ? img_mem[img_idx[3:0]] : 32'hDEAD_BEEF;
  assign weight_readdata = (wei_idx < 32'd9) ? wei_mem[wei_idx[3:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (img_read && !img_waitrequest) icnt <= 0;
    else if (img_read) icnt <= icnt + 1;
    if (weight_read && !weight_waitrequest) wcnt <= 0;
    else if (weight_read) wcnt <= wcnt + 1;
  end

  // Bus protocol observer (sampled mid-cycle)
  int          img_acc_n = 0, wei_acc_n = 0;
  int          run_img0 = 0, run_wei0 = 0;
  logic        img_hold_v = 1'b0, wei_hold_v = 1'b0;
  logic        img_drop_v = 1'b0, wei_drop_v = 1'b0;
  logic [31:0] img_hold_a, wei_hold_a;

  always @(negedge clk) begin
    if (img_drop_v) check("img_read_drop", {31'd0, img_read}, 32'd0);
    if (wei_drop_v) check("wei_read_drop", {31'd0, weight_read}, 32'd0);
    if (img_hold_v) begin
      check("img_read_held", {31'd0, img_read}, 32'd1);
      check("img_addr_stable", img_address, img_hold_a);
    end
    if (wei_hold_v) begin
      check("wei_read_held", {31'd0, weight_read}, 32'd1);
      check("wei_addr_stable", weight_address, wei_hold_a);
    end
    img_drop_v = 1'b0; img_hold_v = 1'b0;
    wei_drop_v = 1'b0; wei_hold_v = 1'b0;
    if (img_read && !img_waitrequest) begin
      check("img_addr", img_address, cur_base + 32'(4 * (img_acc_n - run_img0)));
      img_acc_n++;
      img_drop_v = 1'b1;
    end else if (img_read) begin
      img_hold_v = 1'b1;
      img_hold_a = img_address;
    end
    if (weight_read && !weight_waitrequest) begin
      check("wei_addr", weight_address,
            cur_base + WEI_OFF + 32'(4 * (wei_acc_n - run_wei0)));
      wei_acc_n++;
      wei_drop_v = 1'b1;
    end else if (weight_read) begin
      wei_hold_v = 1'b1;
      wei_hold_a = weight_address;
    end
  end

  typedef struct packed {
    logic [7:0]        k;
    logic [31:0]       base;
    int unsigned       iw;
    int unsigned       ww;
    logic [8:0][31:0]  img;
    logic [8:0][31:0]  wei;
    logic [31:0]       exp_result;
    int unsigned       exp_cycles;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    int unsigned cycles;
    logic [31:0] end_addr;
    logic [15:0] n;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  function automatic vec_t mk(logic [7:0] k, logic [31:0] base, int unsigned iw,
                              int unsigned ww, logic [287:0] img, logic [287:0] wei,
                              logic [31:0] res, int unsigned cyc);
    vec_t v;
    v.k = k; v.base = base; v.iw = iw; v.ww = ww;
    v.img = img; v.wei = wei; v.exp_result = res; v.exp_cycles = cyc;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 9; i++) begin
      img_mem[i] = v.img[i];
      wei_mem[i] = v.wei[i];
    end
    cur_base    = v.base;
    iwait       = v.iw;
    wwait       = v.ww;
    run_img0    = img_acc_n;
    run_wei0    = wei_acc_n;
    base_addr   = v.base;
    kernel_size = v.k;
  endtask

  task automatic run_vec(input vec_t v, input logic chk_restart, input logic [31:0] old_res);
    exp_t        e;
    int unsigned cyc;
    logic        got;
    load(v);
    e.res      = v.exp_result;
    e.cycles   = v.exp_cycles;
    e.n        = {8'd0, v.k} * {8'd0, v.k};
    e.end_addr = v.base + {14'd0, e.n, 2'b00};
    sb.push_back(e);
    start = 1'b1;
    cyc   = 0;
    got   = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        start       = 1'b0;
        base_addr   = ~v.base;
        kernel_size = 8'hFF;
        if (chk_restart) begin
          check("restart_done_low", {31'd0, done}, 32'd0);
          check("restart_result_hold", result, old_res);
        end
      end
      if (done) got = 1'b1;
    end
    e = sb.pop_front();
    check("done_seen", {31'd0, got}, 32'd1);
    check("result", result, e.res);
    check("cycles", cyc, e.cycles);
    check("img_reads", 32'(img_acc_n - run_img0), {16'd0, e.n});
    check("wei_reads", 32'(wei_acc_n - run_wei0), {16'd0, e.n});
    check("addr_img_end", addr_img, e.end_addr);
    check("addr_wei_end", addr_wei, e.end_addr + WEI_OFF);
  endtask

  initial begin
    vec_t va, vb;
    int   guard;

    vecs[0] = mk(8'd2, 32'h0000_0100, 0, 0,
                 {160'd0, 32'd4, 32'd3, 32'd2, 32'd1},
                 {160'd0, 32'd8, 32'd7, 32'd6, 32'd5}, 32'd70, 9);
    vecs[1] = mk(8'd0, 32'h0000_0200, 0, 0, '0, '0, 32'd0, 1);
    vecs[2] = mk(8'd1, 32'h0000_0300, 3, 1,
                 {256'd0, 32'hABCD_FFFD}, {256'd0, 32'h1234_0007}, 32'hFFFF_FFEB, 6);
    vecs[3] = mk(8'd1, 32'h0000_0400, 0, 0,
                 {256'd0, 32'h0000_8000}, {256'd0, 32'h0000_8000}, 32'h4000_0000, 3);
    vecs[4] = mk(8'd3, 32'h0000_0500, 0, 0,
                 {9{32'h0000_7FFF}}, {9{32'h0000_7FFF}}, 32'h3FF7_0009, 19);
    vecs[5] = mk(8'd2, 32'hFFFF_FFF8, 1, 2,
                 {160'd0, 32'd4, 32'd3, 32'h0000_FFFE, 32'h0000_FFFF},
                 {160'd0, 32'd40, 32'd30, 32'd20, 32'd10}, 32'd200, 17);

    reset = 1'b1; start = 1'b0; clear = 1'b0;
    base_addr = '0; kernel_size = '0;
    for (int i = 0; i < 16; i++) begin
      img_mem[i] = '0;
      wei_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_reads", {30'd0, img_read, weight_read}, 32'd0);
    check("rst_addr_img", addr_img, 32'd0);
    check("rst_addr_wei", addr_wei, 32'd0);
    check("writes_tied", {img_writedata | weight_writedata} | {30'd0, img_write, weight_write}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], (i > 0) && (vecs[i].k != 8'd0),
              (i > 0) ? vecs[(i > 0) ? i - 1 : 0].exp_result : 32'd0);

    // Clear while the image master is stalled in FETCH (launched from DONE).
    va = mk(8'd2, 32'h0000_0600, 5, 0, {9{32'h0000_0011}}, {9{32'h0000_0022}}, 32'd0, 0);
    load(va);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    check("abort_img_held", {31'd0, img_read}, 32'd1);
    guard = 0;
    while (img_read && guard < 20) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    check("abort_drained", {31'd0, img_read}, 32'd0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_reads_idle", {30'd0, img_read, weight_read}, 32'd0);
    check("abort_img_count", 32'(img_acc_n - run_img0), 32'd1);
    check("abort_wei_count", 32'(wei_acc_n - run_wei0), 32'd1);

    // start and clear together: clear wins, nothing launches.
    start = 1'b1; clear = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; clear = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("startclr_idle_reads", {30'd0, img_read, weight_read}, 32'd0);
    check("startclr_done", {31'd0, done}, 32'd0);
    check("startclr_no_fetch", 32'(img_acc_n - run_img0), 32'd1);

    // Back-to-back runs: second start lands while in DONE.
    va = mk(8'd1, 32'h0000_0700, 0, 0, {256'd0, 32'd2}, {256'd0, 32'd3}, 32'd6, 3);
    vb = mk(8'd1, 32'h0000_0800, 2, 0, {256'd0, 32'd4}, {256'd0, 32'd5}, 32'd20, 5);
    run_vec(va, 1'b0, 32'd0);
    run_vec(vb, 1'b1, 32'd6);

    // Clear in DONE.
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    check("clear_done", {31'd0, done}, 32'd0);
    check("clear_result", result, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
